// File: rtl/axi_seq_pkg.sv
// Shared types and constants for the AXI command sequencer: the queued
// command record, the sequencer FSM states and the timeout read-data marker.
package axi_seq_pkg;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sync_fifo.sv
// Shallow synchronous FIFO with a show-ahead head word, so a consumer can
// inspect the head and pop it on the same clock edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push;
    logic             pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Queues read/write commands and plays them one at a time onto an AXI master,
// watching for the matching completion handshake or a timeout.
module axi_cmd_sequencer
    import axi_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [31:0]            cmd_addr,
    input  logic [31:0]            cmd_data,
    input  logic [3:0]             cmd_wstrb,
    output logic                   start_read,
    output logic                   start_write,
    output logic [31:0]            addr,
    output logic [31:0]            data,
    output logic [3:0]             wstrb,
    input  logic                   bvalid,
    input  logic                   bready,
    input  logic                   rvalid,
    input  logic                   rready,
    input  logic [31:0]            rdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count,
    output logic [1:0]             state
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    cmd_t       push_word;
    cmd_t       head_word;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       push;

    seq_state_t state_reg, state_next;
    logic        write_reg, write_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic        rsp_write_reg, rsp_write_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    logic        done;

    assign cmd_ready = !fifo_full && !areset;
    assign push      = cmd_valid && cmd_ready;
    assign push_word = '{write: cmd_write, addr: cmd_addr, data: cmd_data, wstrb: cmd_wstrb};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (aclk),
        .srst    (areset),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (fifo_pop),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (q_count)
    );

    // Only the handshake matching the in-flight command type completes it.
    assign done = write_reg ? (bvalid && bready) : (rvalid && rready);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg       <= ST_IDLE;
            write_reg       <= 1'b0;
            addr_reg        <= '0;
            data_reg        <= '0;
            wstrb_reg       <= '0;
            timer_reg       <= '0;
            rsp_write_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            write_reg       <= write_next;
            addr_reg        <= addr_next;
            data_reg        <= data_next;
            wstrb_reg       <= wstrb_next;
            timer_reg       <= timer_next;
            rsp_write_reg   <= rsp_write_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        write_next       = write_reg;
        addr_next        = addr_reg;
        data_next        = data_reg;
        wstrb_next       = wstrb_reg;
        timer_next       = timer_reg;
        rsp_write_next   = rsp_write_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_timeout_next = rsp_timeout_reg;
        fifo_pop         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    write_next = head_word.write;
                    addr_next  = head_word.addr;
                    data_next  = head_word.data;
                    wstrb_next = head_word.wstrb;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_next = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over timeout on the last allowed cycle.
                if (done) begin
                    rsp_write_next   = write_reg;
                    rsp_rdata_next   = write_reg ? 32'h0 : rdata;
                    rsp_timeout_next = 1'b0;
                    state_next       = ST_RESP;
                end else if (timer_reg == TIMER_LAST) begin
                    rsp_write_next   = write_reg;
                    rsp_rdata_next   = TIMEOUT_RDATA;
                    rsp_timeout_next = 1'b1;
                    state_next       = ST_RESP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign start_write = (state_reg == ST_ISSUE) && write_reg;
    assign start_read  = (state_reg == ST_ISSUE) && !write_reg;
    assign addr        = addr_reg;
    assign data        = data_reg;
    assign wstrb       = wstrb_reg;
    assign rsp_valid   = (state_reg == ST_RESP);
    assign rsp_write   = rsp_write_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign busy        = (state_reg != ST_IDLE) || (q_count != '0);
    assign state       = state_reg;

endmodule
